// File: rtl/clk_div_monitor.sv
// Measures each half-period of a slow, asynchronous clock in fast-clock cycles.
// Declares lock after a run of in-tolerance intervals and flags bad intervals or stalls.
module clk_div_monitor #(
   parameter int EXP_HALF = 16,
   parameter int TOL      = 1,
   parameter int LOCK_CNT = 4,
   parameter int CW       = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          slow_clk,
   input  logic          enable,
   input  logic          clr_err,
   output logic [CW-1:0] half_period,
   output logic          meas_valid,
   output logic          locked,
   output logic          err,
   output logic          err_sticky
);

   localparam int GW = $clog2(LOCK_CNT + 1);
   localparam logic [CW:0]   LO_V    = (CW+1)'((EXP_HALF > TOL) ? EXP_HALF - TOL : 0);
   localparam logic [CW:0]   HI_V    = (CW+1)'(EXP_HALF + TOL);
   localparam logic [CW:0]   STALL_V = (CW+1)'(2 * EXP_HALF + TOL);
   localparam logic [CW-1:0] CNT_MAX = '1;
   localparam logic [GW-1:0] LOCK_V  = GW'(LOCK_CNT);

   typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK, LOCKED} state_t;

   state_t        state_q, state_d;
   logic          s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [GW-1:0] good_q, good_d;
   logic [CW-1:0] half_period_q, half_period_d;
   logic          meas_valid_q, meas_valid_d;
   logic          err_q, err_d;
   logic          err_sticky_q, err_sticky_d;

   logic          slow_edge;
   logic [CW:0]   cnt_inc;
   logic [CW-1:0] interval;
   logic          in_tol;
   logic          stall;
   logic [GW-1:0] good_inc;

   always_comb begin
      s1_d = slow_clk;
      s2_d = s1_q;
      s3_d = s2_q;

      slow_edge = s2_q ^ s3_q;
      // One extra bit lets the interval saturate and be range-checked without wrap.
      cnt_inc  = {1'b0, cnt_q} + (CW+1)'(1);
      interval = cnt_inc[CW] ? CNT_MAX : cnt_inc[CW-1:0];
      in_tol   = ({1'b0, interval} >= LO_V) && ({1'b0, interval} <= HI_V);
      stall    = cnt_inc >= STALL_V;
      good_inc = good_q + GW'(1);

      state_d       = state_q;
      cnt_d         = interval;
      good_d        = good_q;
      half_period_d = half_period_q;
      meas_valid_d  = 1'b0;
      err_d         = 1'b0;

      if (!enable) begin
         state_d = IDLE;
         cnt_d   = '0;
         good_d  = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = ACQUIRE;
               cnt_d   = '0;
               good_d  = '0;
            end
            ACQUIRE: begin
               if (slow_edge) begin
                  state_d = TRACK;
                  cnt_d   = '0;
               end
            end
            TRACK, LOCKED: begin
               // A real edge takes priority over a stall reaching threshold in the same cycle.
               if (slow_edge) begin
                  cnt_d         = '0;
                  meas_valid_d  = 1'b1;
                  half_period_d = interval;
                  if (in_tol) begin
                     if (state_q == TRACK) begin
                        good_d = good_inc;
                        if (good_inc == LOCK_V) begin
                           state_d = LOCKED;
                        end
                     end
                  end else begin
                     good_d  = '0;
                     state_d = TRACK;
                     err_d   = (state_q == LOCKED);
                  end
               end else if (stall) begin
                  state_d = ACQUIRE;
                  cnt_d   = '0;
                  good_d  = '0;
                  err_d   = (state_q == LOCKED);
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      err_sticky_d = err_d | (err_sticky_q & ~clr_err);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         s1_q          <= 1'b0;
         s2_q          <= 1'b0;
         s3_q          <= 1'b0;
         cnt_q         <= '0;
         good_q        <= '0;
         half_period_q <= '0;
         meas_valid_q  <= 1'b0;
         err_q         <= 1'b0;
         err_sticky_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         s1_q          <= s1_d;
         s2_q          <= s2_d;
         s3_q          <= s3_d;
         cnt_q         <= cnt_d;
         good_q        <= good_d;
         half_period_q <= half_period_d;
         meas_valid_q  <= meas_valid_d;
         err_q         <= err_d;
         err_sticky_q  <= err_sticky_d;
      end
   end

   assign half_period = half_period_q;
   assign meas_valid  = meas_valid_q;
   assign locked      = (state_q == LOCKED);
   assign err         = err_q;
   assign err_sticky  = err_sticky_q;

endmodule
